// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the EX stage: the 4-bit ALU operation codes, and the
// state encoding of the sequential multiplier FSM.
// No ports (package only).
// ---------------------------------------------------------------------------
package alu_pkg;

  // EX-stage ALU operation codes
  localparam logic [3:0] ALU_MUL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_BEQ  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_BGE  = 4'd7;
  localparam logic [3:0] ALU_MATR = 4'd8;

  // Multiplier FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : alu_pkg

// File: rtl/mult_seq_if.sv
// ---------------------------------------------------------------------------
// mult_seq_if
// Groups the EX-stage request signals and the multiplier's status/result
// signals exchanged between the pipeline and mult_seq.
//   ALU_control  [3:0]      EX-stage ALU code (ALU_MUL starts a multiply)
//   ex_valid                EX stage holds a valid instruction
//   flush                   kill the EX instruction (branch taken)
//   src_A        [XLEN-1:0] multiplicand
//   src_B        [XLEN-1:0] multiplier
//   stall                   freeze PC, IF/ID and ID/EX
//   busy                    multiplier FSM not idle
//   result       [XLEN-1:0] low XLEN bits of the product
//   result_valid            one-cycle result strobe
// master: pipeline side, slave: multiplier side.
// ---------------------------------------------------------------------------
interface mult_seq_if #(
  parameter int XLEN = 32
);

  logic [3:0]      ALU_control;
  logic            ex_valid;
  logic            flush;
  logic [XLEN-1:0] src_A;
  logic [XLEN-1:0] src_B;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output ALU_control, ex_valid, flush, src_A, src_B,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  ALU_control, ex_valid, flush, src_A, src_B,
    output stall, busy, result, result_valid
  );

endinterface : mult_seq_if

// File: rtl/mult_dp.sv
// ---------------------------------------------------------------------------
// mult_dp
// Shift-add datapath of the sequential multiplier: operand registers,
// accumulator, step counter and the held result register.
// Configuration macro: MULT_EARLY_TERM_EN -- when defined, o_last also
// asserts once the shifted multiplier has no set bits left, so the run ends
// early; otherwise o_last asserts only on the final of XLEN steps.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_load                latch operands, clear accumulator and counter
//   i_step                perform one shift-add step
//   i_commit              capture the final product into the result register
//   i_src_a, i_src_b      multiplicand / multiplier
//   o_last                current step is the final one of this operation
//   o_result              held low-XLEN product
// ---------------------------------------------------------------------------
module mult_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_commit,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_acc_next;
  logic [XLEN-1:0] w_b_next;

  // Accumulator is only XLEN wide: carries out of the top bit are dropped,
  // which yields the sign-agnostic low half of the product.
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign w_b_next   = r_b >> 1;

`ifdef MULT_EARLY_TERM_EN
  // Once no multiplier bits remain, further steps cannot change the sum.
  assign o_last = (r_count == CW'(XLEN - 1)) || (w_b_next == '0);
`else
  assign o_last = (r_count == CW'(XLEN - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments and every register
  // (including the operand/accumulator bank) is cleared by the async reset,
  // so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_a     <= i_src_a;
      r_b     <= i_src_b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_step) begin
      r_acc   <= w_acc_next;
      r_a     <= r_a << 1;
      r_b     <= w_b_next;
      r_count <= r_count + CW'(1);
    end
  end

  // Result changes only when an operation completes; a flushed run never
  // commits, so the previous product stays visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
    end else if (i_commit) begin
      r_result <= w_acc_next;
    end
  end

  assign o_result = r_result;

endmodule : mult_dp

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq
// Sequential shift-add multiplier for the EX stage. Holds the IDLE/RUN/DONE
// FSM and the pipeline stall logic; the arithmetic lives in mult_dp.
// A start in cycle C yields result_valid in cycle C+XLEN+1 with stall high
// for cycles C..C+XLEN. With MULT_EARLY_TERM_EN defined (see mult_dp) the
// run ends after the highest set multiplier bit has been consumed.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mult_seq_if.slave: ALU_control, ex_valid, flush, src_A, src_B
//            in; stall, busy, result, result_valid out
// ---------------------------------------------------------------------------
module mult_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  mult_seq_if.slave  bus
);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_start;
  logic       w_step;
  logic       w_last;
  logic       w_commit;

  // Gating with reset_n keeps stall low during reset even when the pipeline
  // presents a mult while the FSM sits in IDLE.
  assign w_start = reset_n & bus.ex_valid & ~bus.flush &
                   (bus.ALU_control == ALU_MUL) & (r_state == ST_IDLE);

  // A flush in RUN kills the step: no datapath update and no commit.
  assign w_step   = (r_state == ST_RUN) & ~bus.flush;
  assign w_commit = w_step & w_last;

  // NOTE: every output of this always_comb gets a default first, so no
  // latch is inferred for paths that leave it unassigned.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.flush)   w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      // ALU_control is ignored here so the held mult is not restarted.
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  mult_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_start),
    .i_step   (w_step),
    .i_commit (w_commit),
    .i_src_a  (bus.src_A),
    .i_src_b  (bus.src_B),
    .o_last   (w_last),
    .o_result (bus.result)
  );

  assign bus.stall        = w_start | w_step;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.result_valid = (r_state == ST_DONE);

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_seq
// Self-checking bench for mult_seq. Expected products (plain truncated
// multiplication) and run lengths are queued when a mult is issued and
// compared when result_valid appears. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// Honours MULT_EARLY_TERM_EN to select the expected run length.
// ---------------------------------------------------------------------------
module tb_mult_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] prod;
    int              runs;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  mult_seq_if #(.XLEN(XLEN)) bus ();

  mult_seq #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t            sb[$];
  int              vectors = 0;
  int              miscompares = 0;
  logic [XLEN-1:0] last_result = '0;

  // Number of RUN cycles the bench expects for a given multiplier.
  function automatic int exp_runs(input logic [XLEN-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    int k = 1;
    for (int i = 0; i < XLEN; i++) if (b[i]) k = i + 1;
    return k;
`else
    return (b === b) ? XLEN : XLEN;
`endif
  endfunction

  task automatic idle_inputs();
    bus.ALU_control = 4'd0;
    bus.ex_valid    = 1'b0;
    bus.flush       = 1'b0;
  endtask

  // Issue one mult in the current cycle and follow it to its result strobe.
  // hold=1 leaves the mult request asserted afterwards (back-to-back use).
  task automatic run_mult(input string name, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int runs,
                          input bit hold);
    exp_t       e;
    logic [2:0] got;
    logic [2:0] want;
    bit         done;
    done   = 1'b0;
    e.prod = a * b;
    e.runs = runs;
    sb.push_back(e);
    bus.src_A       = a;
    bus.src_B       = b;
    bus.ALU_control = ALU_MUL;
    bus.ex_valid    = 1'b1;
    bus.flush       = 1'b0;
    for (int i = 0; i <= runs + 4 && !done; i++) begin
      @(negedge clk);
      got = {bus.stall, bus.busy, bus.result_valid};
      if (i == 0)              want = 3'b100;
      else if (i <= runs)      want = 3'b110;
      else if (i == runs + 1)  want = 3'b011;
      else                     want = 3'b000;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s status cyc %0d: {stall,busy,valid} got %b want %b",
                 name, i, got, want);
      end
      if (bus.result_valid === 1'b1) begin
        done = 1'b1;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s unexpected result_valid: result got %h want none",
                   name, bus.result);
        end else begin
          exp_t h;
          h = sb.pop_front();
          if (bus.result !== h.prod) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, bus.result, h.prod);
          end
          last_result = h.prod;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: result_valid got none want cycle %0d",
               name, runs + 1);
      if (sb.size() > 0) sb.delete(0);
    end
    if (!hold) idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.src_A = '0;
    bus.src_B = '0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000 || bus.result !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got stall=%b busy=%b valid=%b result=%h want all 0",
               bus.stall, bus.busy, bus.result_valid, bus.result);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_mult("mul_7x6", 32'd7, 32'd6, exp_runs(32'd6), 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_boundary();
    run_mult("mul_ffffffff_x2", 32'hFFFF_FFFF, 32'd2, exp_runs(32'd2), 1'b0);
    run_mult("mul_80000000_x2", 32'h8000_0000, 32'd2, exp_runs(32'd2), 1'b0);
    run_mult("mul_0_xffffffff", 32'd0, 32'hFFFF_FFFF, exp_runs(32'hFFFF_FFFF), 1'b0);
    run_mult("mul_ff_xff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_runs(32'hFFFF_FFFF), 1'b0);
    for (int n = 0; n < 3; n++) begin
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      a = $urandom;
      b = $urandom;
      run_mult("mul_random", a, b, exp_runs(b), 1'b0);
    end
  endtask

  // Mult request stays asserted through DONE; the next mult must start from
  // IDLE in the following cycle, not from a restart in DONE.
  task automatic test_back_to_back();
    run_mult("b2b_first", 32'd12345, 32'd678, exp_runs(32'd678), 1'b1);
    run_mult("b2b_second", 32'hDEAD_BEEF, 32'h0001_0003, exp_runs(32'h0001_0003), 1'b0);
  endtask

  task automatic test_non_mult();
    for (int code = 0; code < 16; code++) begin
      if (code == int'(ALU_MUL)) continue;
      bus.ALU_control = 4'(code);
      bus.ex_valid    = 1'b1;
      bus.src_A       = $urandom;
      bus.src_B       = $urandom;
      @(negedge clk);
      vectors++;
      if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL non_mult code %0d: {stall,busy,valid} got %b want 000",
                 code, {bus.stall, bus.busy, bus.result_valid});
      end
      @(posedge clk);
      #1;
    end
    bus.ALU_control = ALU_MUL;
    for (int n = 0; n < 3; n++) begin
      bus.ex_valid = 1'b0;
      bus.flush    = (n == 2);
      if (n == 2) bus.ex_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL mult_no_issue %0d: {stall,busy,valid} got %b want 000",
                 n, {bus.stall, bus.busy, bus.result_valid});
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] prev;
    prev            = last_result;
    bus.src_A       = 32'd123;
    bus.src_B       = 32'h8000_1234;
    bus.ALU_control = ALU_MUL;
    bus.ex_valid    = 1'b1;
    bus.flush       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL flush pre cyc %0d: stall got %b want 1", i, bus.stall);
      end
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.stall, bus.busy, bus.result_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL flush cycle: {stall,busy,valid} got %b want 010",
               {bus.stall, bus.busy, bus.result_valid});
    end
    @(posedge clk);
    #1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000 || bus.result !== prev) begin
        miscompares++;
        $display("FAIL after_flush %0d: stall=%b busy=%b valid=%b result=%h want 0 0 0 %h",
                 i, bus.stall, bus.busy, bus.result_valid, bus.result, prev);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mid_reset();
    bus.src_A       = 32'd11;
    bus.src_B       = 32'hF000_0001;
    bus.ALU_control = ALU_MUL;
    bus.ex_valid    = 1'b1;
    bus.flush       = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.busy, bus.result_valid} !== 3'b000 || bus.result !== '0) begin
      miscompares++;
      $display("FAIL mid_reset outputs: stall=%b busy=%b valid=%b result=%h want all 0",
               bus.stall, bus.busy, bus.result_valid, bus.result);
    end
    last_result = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_mult("after_reset_3x3", 32'd3, 32'd3, exp_runs(32'd3), 1'b0);
  endtask

`ifdef MULT_EARLY_TERM_EN
  task automatic test_early_term();
    run_mult("early_5x0", 32'd5, 32'd0, 1, 1'b0);
    run_mult("early_5x3", 32'd5, 32'd3, 2, 1'b0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_non_mult();
    test_flush();
    test_mid_reset();
`ifdef MULT_EARLY_TERM_EN
    test_early_term();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mult_seq
